// File: rtl/matrix_stream_ctrl.sv
// rtl/matrix_stream_ctrl.sv - valid/ready element stream to 2x2 multiplier operands and result stream out
// Loads A then B row-major, captures C one cycle later, streams C row-major with last.
module matrix_stream_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_ROWS   = 2,
  parameter int MAX_COLS   = 2
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             s_valid,
  output logic                                             s_ready,
  input  logic [DATA_WIDTH-1:0]                            s_data,
  output logic                                             m_valid,
  input  logic                                             m_ready,
  output logic [DATA_WIDTH-1:0]                            m_data,
  output logic                                             m_last,
  output logic [MAX_ROWS-1:0][MAX_COLS-1:0][DATA_WIDTH-1:0] mat_a_o,
  output logic [MAX_ROWS-1:0][MAX_COLS-1:0][DATA_WIDTH-1:0] mat_b_o,
  input  logic [MAX_ROWS-1:0][MAX_COLS-1:0][DATA_WIDTH-1:0] mat_c_i,
  output logic                                             busy
);

  localparam int NUM_ELEM = MAX_ROWS * MAX_COLS;
  localparam int IDX_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam int ROW_W    = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;
  localparam int COL_W    = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, CAPTURE, SEND} state_t;

  state_t                                             state_q;
  logic [IDX_W-1:0]                                   idx_q;
  logic [MAX_ROWS-1:0][MAX_COLS-1:0][DATA_WIDTH-1:0]  a_q, b_q, c_q;
  logic                                               s_ready_q, m_valid_q, m_last_q, busy_q;
  logic [DATA_WIDTH-1:0]                              m_data_q;

  logic [IDX_W-1:0] idx_inc;
  logic [ROW_W-1:0] cur_row, nxt_row;
  logic [COL_W-1:0] cur_col, nxt_col;

  // Row-major mapping of the current and following linear index.
  always_comb begin
    idx_inc = idx_q + IDX_W'(1);
    cur_row = ROW_W'(32'(idx_q) / MAX_COLS);
    cur_col = COL_W'(32'(idx_q) % MAX_COLS);
    nxt_row = ROW_W'(32'(idx_inc) / MAX_COLS);
    nxt_col = COL_W'(32'(idx_inc) % MAX_COLS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD_A;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        LOAD_A: begin
          s_ready_q <= 1'b1;
          if (s_valid && s_ready_q) begin
            a_q[cur_row][cur_col] <= s_data;
            busy_q                <= 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              state_q <= LOAD_B;
            end else begin
              idx_q <= idx_inc;
            end
          end
        end
        LOAD_B: begin
          s_ready_q <= 1'b1;
          if (s_valid && s_ready_q) begin
            b_q[cur_row][cur_col] <= s_data;
            if (idx_q == LAST_IDX) begin
              idx_q     <= '0;
              s_ready_q <= 1'b0;
              state_q   <= CAPTURE;
            end else begin
              idx_q <= idx_inc;
            end
          end
        end
        CAPTURE: begin
          c_q     <= mat_c_i;
          idx_q   <= '0;
          state_q <= SEND;
        end
        SEND: begin
          // First SEND cycle only loads the output registers; afterwards each handshake advances.
          if (!m_valid_q) begin
            m_valid_q <= 1'b1;
            m_data_q  <= c_q[cur_row][cur_col];
            m_last_q  <= (idx_q == LAST_IDX);
          end else if (m_ready) begin
            if (m_last_q) begin
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              busy_q    <= 1'b0;
              idx_q     <= '0;
              s_ready_q <= 1'b1;
              state_q   <= LOAD_A;
            end else begin
              idx_q    <= idx_inc;
              m_data_q <= c_q[nxt_row][nxt_col];
              m_last_q <= (idx_inc == LAST_IDX);
            end
          end
        end
      endcase
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign busy    = busy_q;
  assign mat_a_o = a_q;
  assign mat_b_o = b_q;

endmodule
